ntt_stage_sched: RTL

- Sequences one forward in-place Cooley-Tukey NTT pass (bit-reversed twiddle order) over an N-point coefficient memory.
- Emits one butterfly command per accepted cycle: coefficient addresses a and b, plus the twiddle ROM address `psi_addr`.
- `psi_addr` drives the 3-bit twiddle table directly when LOG_N=3.
- Sits between the top-level control FSM and the butterfly datapath. Inserts programmable drain gaps between stages so the pipelined butterfly finishes writing back before the next stage reads.

---
 rtl/ntt_stage_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched: walks one forward in-place Cooley-Tukey NTT pass over an
// N-point memory, issuing one butterfly command (a, b, twiddle index) per
// accepted handshake. It leaves a programmable idle gap after every stage so
// the butterfly pipeline can finish writing back before the next stage reads.
module ntt_stage_sched #(
  parameter int LOG_N     = 3,
  parameter int STAGE_GAP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             bf_valid,
  input  logic             bf_ready,
  output logic [LOG_N-1:0] bf_addr_a,
  output logic [LOG_N-1:0] bf_addr_b,
  output logic [LOG_N-1:0] psi_addr,
  output logic [LOG_N-1:0] stage,
  output logic             bf_last
);

  // Butterfly index k counts 0..N/2-1 within a stage; stage s counts 0..LOG_N-1.
  localparam logic [LOG_N-1:0] K_LAST = LOG_N'((1 << (LOG_N - 1)) - 1);
  localparam logic [LOG_N-1:0] S_LAST = LOG_N'(LOG_N - 1);
  localparam logic [LOG_N-1:0] HALF   = LOG_N'(1 << (LOG_N - 1));
  localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);
  // With no gap configured the GAP state is never entered, so its terminal
  // count value is irrelevant; clamp to zero to keep the constant in range.
  localparam logic [3:0]       G_LAST = (STAGE_GAP == 0) ? 4'd0 : 4'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LOG_N-1:0] s_q, s_d;
  logic [LOG_N-1:0] k_q, k_d;
  logic [3:0]       g_q, g_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [LOG_N-1:0] addr_a_q, addr_a_d;
  logic [LOG_N-1:0] addr_b_q, addr_b_d;
  logic [LOG_N-1:0] psi_q, psi_d;

  logic [LOG_N-1:0] t_v;
  logic [LOG_N-1:0] i_v;
  logic [LOG_N-1:0] j_v;
  logic [LOG_N-1:0] a_v;

  // Next-state sequencing of stage/butterfly/gap counters.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    g_d     = g_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (bf_ready) begin
          if (k_q != K_LAST) begin
            k_d = k_q + ONE;
          end else begin
            k_d = '0;
            g_d = '0;
            if (STAGE_GAP > 0) begin
              state_d = S_GAP;
            end else if (s_q == S_LAST) begin
              state_d = S_DONE;
            end else begin
              s_d = s_q + ONE;
            end
          end
        end
      end
      S_GAP: begin
        g_d = g_q + 4'd1;
        if (g_q == G_LAST) begin
          g_d = '0;
          if (s_q == S_LAST) begin
            state_d = S_DONE;
          end else begin
            s_d     = s_q + ONE;
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address arithmetic for the command that will be presented next cycle.
  // t = N >> (s+1) equals (N/2) >> s, the group index i picks the twiddle,
  // and i*2t is formed as (i << 1) << (LOG_N-1-s) so nothing leaves LOG_N bits.
  always_comb begin
    t_v = HALF >> s_d;
    i_v = k_d >> (S_LAST - s_d);
    j_v = k_d & (t_v - ONE);
    a_v = ((i_v << 1) << (S_LAST - s_d)) | j_v;

    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    valid_d  = (state_d == S_RUN);
    last_d   = (state_d == S_RUN) && (s_d == S_LAST) && (k_d == K_LAST);
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    psi_d    = psi_q;
    if (state_d == S_RUN) begin
      addr_a_d = a_v;
      addr_b_d = a_v + t_v;
      psi_d    = (ONE << s_d) + i_v;
    end
  end

  // Single register bank for FSM state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      s_q      <= '0;
      k_q      <= '0;
      g_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      psi_q    <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      k_q      <= k_d;
      g_q      <= g_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      psi_q    <= psi_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bf_valid  = valid_q;
  assign bf_last   = last_q;
  assign bf_addr_a = addr_a_q;
  assign bf_addr_b = addr_b_q;
  assign psi_addr  = psi_q;
  assign stage     = s_q;

endmodule
